rc_channel_scheduler: RTL and testbench

Sequencer between the per-channel RC pulse-measurement units and the outbound message channel. Buffers one measured pulse width per channel, shares the single output port among channels with round-robin arbitration and a valid/ready handshake, tracks per-channel overruns, and optionally generates failsafe messages for channels that stop producing pulses. Sits downstream of the `PulseMeasure` instances and replaces the plain pulse arbiter in the RC read path.

---
 rtl/rc_channel_scheduler.sv | 145 ++++++++++++++
 tb/tb_rc_channel_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rc_channel_scheduler.sv
// rc_channel_scheduler: buffers one pulse width per RC channel and sends them round-robin over a valid/ready port.
// Define RC_FAILSAFE_EN to add per-channel watchdogs that emit one failsafe message per loss episode.
module rc_channel_scheduler #(
    parameter int TOTAL    = 6,
    parameter int WIDTH    = 17,
    parameter int TICK_DIV = 50,
    parameter int TIMEOUT  = 25000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [TOTAL-1:0]       rdy,
    input  logic [TOTAL*WIDTH-1:0] bus_in,
    input  logic [TOTAL-1:0]       enable,
    output logic [WIDTH-1:0]       out_data,
    output logic [2:0]             out_sel,
    output logic                   out_failsafe,
    output logic                   out_stb,
    input  logic                   out_rdy,
    output logic [TOTAL-1:0]       overrun,
    input  logic                   overrun_clr
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [2:0]       ptr_q, ptr_d, sel_q, sel_d, gnt;
    logic [3:0]       idx;
    logic             gnt_vld, fsf_q, fsf_d;
    logic [TOTAL-1:0] cap, req, gnt_oh, pend_q, pend_d, ovr_q, ovr_d, fs_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] slot_q [TOTAL];
    logic [WIDTH-1:0] slot_d [TOTAL];

    assign cap = rdy & enable;
    assign req = pend_q | fs_q;

    // Scan downward so the lowest offset from ptr wins.
    always_comb begin
        gnt = '0;
        gnt_vld = 1'b0;
        idx = '0;
        for (int k = TOTAL - 1; k >= 0; k--) begin
            idx = 4'(ptr_q) + 4'(k);
            idx = (idx >= 4'(TOTAL)) ? idx - 4'(TOTAL) : idx;
            if (req[idx[2:0]]) begin
                gnt = idx[2:0];
                gnt_vld = 1'b1;
            end
        end
        gnt_oh = (state_q == IDLE && gnt_vld) ? TOTAL'(1) << gnt : '0;
    end

    // A capture on the channel being granted keeps pending set and is not an overrun.
    always_comb begin
        pend_d = enable & (cap | (pend_q & ~gnt_oh));
        ovr_d = (ovr_q & ~{TOTAL{overrun_clr}}) | (cap & pend_q & ~gnt_oh);
        for (int i = 0; i < TOTAL; i++)
            slot_d[i] = cap[i] ? bus_in[WIDTH*i +: WIDTH] : slot_q[i];
    end

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        data_d = data_q;
        sel_d = sel_q;
        fsf_d = fsf_q;
        if (state_q == IDLE && gnt_vld) begin
            state_d = SEND;
            sel_d = gnt;
            data_d = pend_q[gnt] ? slot_q[gnt] : '0;
            fsf_d = ~pend_q[gnt];
        end else if (state_q == SEND && out_rdy) begin
            state_d = IDLE;
            ptr_d = (sel_q == 3'(TOTAL - 1)) ? 3'd0 : sel_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q <= '0;
            sel_q <= '0;
            data_q <= '0;
            fsf_q <= 1'b0;
            pend_q <= '0;
            ovr_q <= '0;
            slot_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            sel_q <= sel_d;
            data_q <= data_d;
            fsf_q <= fsf_d;
            pend_q <= pend_d;
            ovr_q <= ovr_d;
            slot_q <= slot_d;
        end
    end

`ifdef RC_FAILSAFE_EN
    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [PW-1:0]    pre_q, pre_d;
    logic             tick;
    logic [CW-1:0]    cnt_q [TOTAL];
    logic [CW-1:0]    cnt_d [TOTAL];
    logic [TOTAL-1:0] lost_q, lost_d, fs_d;

    // lost blocks re-arming until the next capture, giving one notice per loss episode.
    always_comb begin
        tick = pre_q == PW'(TICK_DIV - 1);
        pre_d = tick ? '0 : pre_q + 1'b1;
        for (int i = 0; i < TOTAL; i++) begin
            cnt_d[i] = (!enable[i] || cap[i]) ? '0 :
                       (tick && cnt_q[i] != CW'(TIMEOUT)) ? cnt_q[i] + 1'b1 : cnt_q[i];
            lost_d[i] = enable[i] & ~cap[i] & (lost_q[i] | (cnt_q[i] == CW'(TIMEOUT)));
            fs_d[i] = enable[i] & ~cap[i] & ((fs_q[i] & ~(gnt_oh[i] & ~pend_q[i])) |
                      (cnt_q[i] == CW'(TIMEOUT) & ~lost_q[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            lost_q <= '0;
            fs_q <= '0;
            cnt_q <= '{default: '0};
        end else begin
            pre_q <= pre_d;
            lost_q <= lost_d;
            fs_q <= fs_d;
            cnt_q <= cnt_d;
        end
    end
`else
    assign fs_q = '0;
`endif

    assign out_data = data_q;
    assign out_sel = sel_q;
    assign out_failsafe = fsf_q;
    assign out_stb = state_q == SEND;
    assign overrun = ovr_q;
endmodule

// File: tb/tb_rc_channel_scheduler.sv
// tb_rc_channel_scheduler: directed scenarios plus randomized traffic checked every cycle against a behavioural model.
module tb_rc_channel_scheduler;
    localparam int T = 6, W = 17, TD = 2, TO = 10;
`ifdef RC_FAILSAFE_EN
    localparam int FS = 1;
`else
    localparam int FS = 0;
`endif

    logic           clk = 0, rst_n = 1;
    logic [T-1:0]   rdy = '0, enable = '1, overrun;
    logic [T*W-1:0] bus_in = '0;
    logic [W-1:0]   out_data;
    logic [2:0]     out_sel;
    logic           out_failsafe, out_stb, out_rdy = 1'b1, overrun_clr = 1'b0;

    rc_channel_scheduler #(.TOTAL(T), .WIDTH(W), .TICK_DIV(TD), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .bus_in(bus_in), .enable(enable),
        .out_data(out_data), .out_sel(out_sel), .out_failsafe(out_failsafe),
        .out_stb(out_stb), .out_rdy(out_rdy), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: per-channel buffers, one outstanding message, next-start pointer.
    bit         m_pend [T], m_ovr [T], m_fsp [T], m_lost [T];
    logic [W-1:0] m_val [T];
    int         m_cnt [T];
    int         m_pre, m_ptr, m_sel, g;
    bit         m_busy, m_fs, tick, c, old_p;
    logic [W-1:0] m_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < T; i++) begin
                m_pend[i] = 0; m_ovr[i] = 0; m_fsp[i] = 0; m_lost[i] = 0; m_val[i] = '0; m_cnt[i] = 0;
            end
            m_pre = 0; m_ptr = 0; m_sel = 0; m_busy = 0; m_fs = 0; m_data = '0;
        end else begin
            g = -1;
            if (!m_busy)
                for (int k = T - 1; k >= 0; k--)
                    if (m_pend[(m_ptr + k) % T] || m_fsp[(m_ptr + k) % T]) g = (m_ptr + k) % T;
            if (m_busy) begin
                if (out_rdy) begin
                    m_busy = 0;
                    m_ptr = (m_sel + 1) % T;
                end
            end else if (g >= 0) begin
                m_busy = 1;
                m_sel = g;
                m_fs = !m_pend[g];
                m_data = m_pend[g] ? m_val[g] : '0;
            end
            tick = (m_pre == TD - 1);
            m_pre = tick ? 0 : m_pre + 1;
            for (int i = 0; i < T; i++) begin
                c = rdy[i] && enable[i];
                old_p = m_pend[i];
                if (c && old_p && g != i) m_ovr[i] = 1;
                else if (overrun_clr) m_ovr[i] = 0;
                if (c) m_val[i] = bus_in[W*i +: W];
                m_pend[i] = enable[i] && (c || (old_p && g != i));
                if (FS == 1) begin
                    if (!enable[i] || c) begin
                        m_fsp[i] = 0; m_lost[i] = 0; m_cnt[i] = 0;
                    end else begin
                        if (m_cnt[i] == TO && !m_lost[i]) begin
                            m_fsp[i] = 1; m_lost[i] = 1;
                        end else if (g == i && !old_p) m_fsp[i] = 0;
                        if (tick && m_cnt[i] < TO) m_cnt[i]++;
                    end
                end
            end
        end
    end

    // Accepted messages, split into data and failsafe streams.
    int q_sel[$], q_data[$], f_sel[$], f_data[$];
    always @(posedge clk)
        if (rst_n && out_stb && out_rdy) begin
            if (out_failsafe) begin f_sel.push_back(out_sel); f_data.push_back(out_data); end
            else begin q_sel.push_back(out_sel); q_data.push_back(out_data); end
        end

    task automatic clear_q();
        q_sel.delete(); q_data.delete(); f_sel.delete(); f_data.delete();
    endtask

    task automatic step();
        logic [T-1:0] mo;
        @(negedge clk);
        for (int i = 0; i < T; i++) mo[i] = m_ovr[i];
        check("stb", out_stb, m_busy);
        check("ovr", overrun, mo);
        if (m_busy) begin
            check("sel", out_sel, m_sel);
            check("data", out_data, m_data);
            check("fs", out_failsafe, m_fs);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_slice(input int ch, input logic [W-1:0] v);
        bus_in[W*ch +: W] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; rdy = '0; enable = '1; out_rdy = 1'b1; overrun_clr = 1'b0;
        step();
        rst_n = 1;
    endtask

    int n, ord;
    bit done;

    initial begin
        do_reset();
        check("rst_stb", out_stb, 0);
        check("rst_data", out_data, 0);
        check("rst_sel", out_sel, 0);
        check("rst_ovr", overrun, 0);

        // single capture
        rdy = 6'b000100; set_slice(2, 17'h05DC);
        step(); rdy = '0;
        step();
        check("t1_stb", out_stb, 1);
        check("t1_sel", out_sel, 2);
        check("t1_data", out_data, 17'h05DC);
        check("t1_fs", out_failsafe, 0);
        step();
        check("t1_drop", out_stb, 0);

        // round-robin with a re-strobe while ch3 is being sent
        do_reset(); clear_q(); done = 0;
        rdy = 6'b101001;
        for (int i = 0; i < T; i++) set_slice(i, W'(i + 16));
        step(); rdy = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            rdy = (!done && out_stb && out_sel == 3) ? 6'b100001 : '0;
            if (rdy != 0) done = 1;
        end
        ord = 0;
        foreach (q_sel[i]) ord = (ord << 4) | q_sel[i];
        check("t2_cnt", q_sel.size(), 4);
        check("t2_order", ord, 32'h0350);
        check("t2_ovr5", overrun[5], 1);
        overrun_clr = 1; step(); overrun_clr = 0;
        check("t2_clr", overrun, 0);

        // backpressure and overrun
        do_reset(); out_rdy = 0;
        rdy = 6'b001000; set_slice(3, 17'h33);
        step(); rdy = '0; step();
        rdy = 6'b000010; set_slice(1, 17'h100); step();
        set_slice(1, 17'h200); step();
        rdy = '0; step();
        check("t3_ovr1", overrun[1], 1);
        clear_q(); out_rdy = 1;
        steps(8);
        n = 0;
        foreach (q_sel[i]) if (q_sel[i] == 1) begin
            n++;
            check("t3_data", q_data[i], 17'h200);
        end
        check("t3_cnt1", n, 1);
        overrun_clr = 1; step(); overrun_clr = 0;
        check("t3_clr", overrun, 0);

        // enable mask
        do_reset(); clear_q(); enable = 6'b000001;
        rdy = '1;
        for (int i = 0; i < T; i++) set_slice(i, W'($urandom));
        step(); rdy = '0;
        steps(8);
        check("t4_cnt", q_sel.size(), 1);
        check("t4_sel", q_sel.size() > 0 ? q_sel[0] : 99, 0);
        out_rdy = 0; rdy = 6'b000001; step(); rdy = '0; steps(2);
        rdy = 6'b000001; step(); rdy = '0; enable = '0; step();
        clear_q(); out_rdy = 1;
        steps(8);
        check("t4_dis", q_sel.size(), 1);

        // watchdog: one notice per loss episode, re-armed by a capture
        do_reset(); enable = 6'b010000; clear_q();
        steps(60);
        check("t5_fs1", f_sel.size(), FS);
        if (f_sel.size() > 0) begin
            check("t5_sel", f_sel[0], 4);
            check("t5_data", f_data[0], 0);
        end
        clear_q();
        rdy = 6'b010000; set_slice(4, 17'h1234); step(); rdy = '0;
        steps(60);
        check("t5_dat", q_sel.size(), 1);
        check("t5_fs2", f_sel.size(), FS);

        // reset in the middle of SEND
        do_reset(); out_rdy = 0;
        rdy = 6'b000100; set_slice(2, 17'h77); step(); rdy = '0; step();
        check("t6_stb", out_stb, 1);
        #2 rst_n = 0;
        #1 check("t6_async", out_stb, 0);
        @(negedge clk); rst_n = 1; out_rdy = 1; clear_q();
        steps(10);
        check("t6_quiet", q_sel.size() + f_sel.size(), 0);

        // randomized traffic, dense and sparse phases
        do_reset();
        for (int p = 0; p < 6; p++)
            for (int i = 0; i < 500; i++) begin
                rdy = (p % 2 == 0) ? T'($urandom & $urandom & $urandom)
                                   : T'($urandom & $urandom & $urandom & $urandom & $urandom & $urandom);
                for (int k = 0; k < T; k++) set_slice(k, W'($urandom));
                out_rdy = ($urandom % 4) != 0;
                overrun_clr = ($urandom % 40) == 0;
                if ($urandom % 50 == 0) enable[$urandom % T] ^= 1'b1;
                step();
            end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
